// File: rtl/shoot_pkg.sv
// Shared types and screen constants for the shooter game blocks.
package shoot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_SPAWN
  } state_e;

  localparam int SCREEN_W_PX = 640;
  localparam int SCREEN_H_PX = 480;
  localparam int XW_DEF      = 10;
  localparam int YW_DEF      = 10;

  function automatic int slot_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bullet_hit_test.sv
// N-way bullet box comparator with a registered hit flag
// for the VGA colour stage.
module bullet_hit_test #(
  parameter int N_SLOTS = 8,
  parameter int XW      = 10,
  parameter int YW      = 10,
  parameter int BW      = 4,
  parameter int BH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic [N_SLOTS-1:0]    i_valid,
  input  logic [N_SLOTS*XW-1:0] i_x,
  input  logic [N_SLOTS*YW-1:0] i_y,
  input  logic [XW-1:0]         i_qx,
  input  logic [YW-1:0]         i_qy,
  output logic                  o_hit
);

  localparam logic [XW:0] LBW = (XW+1)'(BW);
  localparam logic [YW:0] LBH = (YW+1)'(BH);

  logic [XW:0]        w_qx;
  logic [YW:0]        w_qy;
  logic [N_SLOTS-1:0] w_in;
  logic               r_hit;

  assign w_qx = {1'b0, i_qx};
  assign w_qy = {1'b0, i_qy};

  // One extra bit so a box near the right/bottom edge cannot wrap.
  for (genvar g = 0; g < N_SLOTS; g++) begin : g_box
    logic [XW:0] w_bx;
    logic [YW:0] w_by;
    assign w_bx = {1'b0, i_x[g*XW +: XW]};
    assign w_by = {1'b0, i_y[g*YW +: YW]};
    assign w_in[g] = i_valid[g]
                   && (w_qx >= w_bx)
                   && (w_qx < w_bx + LBW)
                   && (w_qy >= w_by)
                   && (w_qy < w_by + LBH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= !i_clear && (|w_in);
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/bullet_pool.sv
// N-slot bullet pool: per-frame move, rate-limited spawn, pixel hit query.
// Define BULLET_DUAL_EN to spawn twin bullets either side of the player.
module bullet_pool
  import shoot_pkg::*;
#(
  parameter int N_SLOTS   = 8,
  parameter int XW        = XW_DEF,
  parameter int YW        = YW_DEF,
  parameter int SPEED     = 4,
  parameter int COOLDOWN  = 6,
  parameter int BW        = 4,
  parameter int BH        = 8,
  parameter int SPAWN_OFS = 8
`ifdef BULLET_DUAL_EN
  ,
  parameter int SCREEN_W  = SCREEN_W_PX,
  parameter int DUAL_OFS  = 6
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic                         fire,
  input  logic                         gameover,
  input  logic [XW-1:0]                player_x,
  input  logic [YW-1:0]                player_y,
  input  logic [XW-1:0]                query_x,
  input  logic [YW-1:0]                query_y,
  output logic [N_SLOTS-1:0]           bullet_valid,
  output logic [N_SLOTS*XW-1:0]        bullet_x,
  output logic [N_SLOTS*YW-1:0]        bullet_y,
  output logic [$clog2(N_SLOTS+1)-1:0] active_count,
  output logic                         full,
  output logic                         pix_hit,
  output logic                         overrun
);

  localparam int IW  = slot_idx_w(N_SLOTS);
  localparam int CW  = $clog2(N_SLOTS+1);
  localparam int CDW = $clog2(COOLDOWN+2);

  localparam logic [IW-1:0]  LAST_IDX = IW'(N_SLOTS-1);
  localparam logic [YW-1:0]  LSPEED   = YW'(SPEED);
  localparam logic [YW-1:0]  LOFS     = YW'(SPAWN_OFS);
  localparam logic [CDW-1:0] LCD      = CDW'(COOLDOWN);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IW-1:0]      r_idx;
  logic [N_SLOTS-1:0] r_valid;
  logic [XW-1:0]      r_x [N_SLOTS];
  logic [YW-1:0]      r_y [N_SLOTS];
  logic [CDW-1:0]     r_cd;
  logic               r_overrun;

  logic [IW-1:0]      w_s0;
  logic               w_has0;
  logic               w_spawn;
  logic [YW-1:0]      w_sy;
  logic [CW-1:0]      w_cnt;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (gameover) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (frame_tick) w_state_nxt = ST_UPDATE;
        end
        ST_UPDATE: begin
          if (r_idx == LAST_IDX) w_state_nxt = ST_SPAWN;
        end
        ST_SPAWN: begin
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Lowest free slot (and the next one for twin spawns).
`ifdef BULLET_DUAL_EN
  logic [IW-1:0] w_s1;
  logic          w_has1;
  logic [XW-1:0] w_xl;
  logic [XW-1:0] w_xr;
  logic [XW:0]   w_xr_sum;

  assign w_xl = (player_x >= XW'(DUAL_OFS))
              ? player_x - XW'(DUAL_OFS) : '0;
  assign w_xr_sum = {1'b0, player_x} + (XW+1)'(DUAL_OFS);
  assign w_xr = (w_xr_sum > (XW+1)'(SCREEN_W-1))
              ? XW'(SCREEN_W-1) : w_xr_sum[XW-1:0];
`endif

  always_comb begin
    w_s0   = '0;
    w_has0 = 1'b0;
`ifdef BULLET_DUAL_EN
    w_s1   = '0;
    w_has1 = 1'b0;
`endif
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!r_valid[i]) begin
        if (!w_has0) begin
          w_s0   = IW'(i);
          w_has0 = 1'b1;
        end
`ifdef BULLET_DUAL_EN
        else if (!w_has1) begin
          w_s1   = IW'(i);
          w_has1 = 1'b1;
        end
`endif
      end
    end
  end

  assign w_spawn = fire && (r_cd == '0) && w_has0;
  assign w_sy    = (player_y >= LOFS) ? player_y - LOFS : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx   <= '0;
      r_valid <= '0;
      r_cd    <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else if (gameover) begin
      r_idx   <= '0;
      r_valid <= '0;
      r_cd    <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (frame_tick) begin
            r_idx <= '0;
            if (r_cd != '0) r_cd <= r_cd - 1'b1;
          end
        end
        ST_UPDATE: begin
          r_idx <= r_idx + 1'b1;
          if (r_valid[r_idx]) begin
            if (r_y[r_idx] >= LSPEED) begin
              r_y[r_idx] <= r_y[r_idx] - LSPEED;
            end else begin
              r_valid[r_idx] <= 1'b0;
            end
          end
        end
        ST_SPAWN: begin
          if (w_spawn) begin
            r_cd <= LCD;
`ifdef BULLET_DUAL_EN
            if (w_has1) begin
              r_valid[w_s0] <= 1'b1;
              r_x[w_s0]     <= w_xl;
              r_y[w_s0]     <= w_sy;
              r_valid[w_s1] <= 1'b1;
              r_x[w_s1]     <= w_xr;
              r_y[w_s1]     <= w_sy;
            end else begin
              r_valid[w_s0] <= 1'b1;
              r_x[w_s0]     <= player_x;
              r_y[w_s0]     <= w_sy;
            end
`else
            r_valid[w_s0] <= 1'b1;
            r_x[w_s0]     <= player_x;
            r_y[w_s0]     <= w_sy;
`endif
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

  // Ticks landing mid-frame are dropped but remembered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (!gameover && frame_tick && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_cnt = w_cnt + CW'(r_valid[i]);
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_out
    assign bullet_x[g*XW +: XW] = r_x[g];
    assign bullet_y[g*YW +: YW] = r_y[g];
  end

  assign bullet_valid = r_valid;
  assign active_count = w_cnt;
  assign full         = &r_valid;
  assign overrun      = r_overrun;

  bullet_hit_test #(
    .N_SLOTS (N_SLOTS),
    .XW      (XW),
    .YW      (YW),
    .BW      (BW),
    .BH      (BH)
  ) u_hit (
    .clk     (clk),
    .rst     (rst),
    .i_clear (gameover),
    .i_valid (r_valid),
    .i_x     (bullet_x),
    .i_y     (bullet_y),
    .i_qx    (query_x),
    .i_qy    (query_y),
    .o_hit   (pix_hit)
  );

endmodule

// File: tb/tb_bullet_pool.sv
// Randomised bench for bullet_pool against a frame-level pool model.
module tb_bullet_pool;

  localparam int N     = 8;
  localparam int XW    = 10;
  localparam int YW    = 10;
  localparam int SPEED = 4;
  localparam int CD    = 6;
  localparam int BW    = 4;
  localparam int BH    = 8;
  localparam int SOFS  = 8;
  localparam int SCR_W = 640;
  localparam int DOFS  = 6;
  localparam int CW    = $clog2(N+1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              frame_tick = 1'b0;
  logic              fire = 1'b0;
  logic              gameover = 1'b0;
  logic [XW-1:0]     player_x = '0;
  logic [YW-1:0]     player_y = '0;
  logic [XW-1:0]     query_x = '0;
  logic [YW-1:0]     query_y = '0;
  logic [N-1:0]      bullet_valid;
  logic [N*XW-1:0]   bullet_x;
  logic [N*YW-1:0]   bullet_y;
  logic [CW-1:0]     active_count;
  logic              full;
  logic              pix_hit;
  logic              overrun;

  bullet_pool dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .fire         (fire),
    .gameover     (gameover),
    .player_x     (player_x),
    .player_y     (player_y),
    .query_x      (query_x),
    .query_y      (query_y),
    .bullet_valid (bullet_valid),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .active_count (active_count),
    .full         (full),
    .pix_hit      (pix_hit),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // reference pool
  bit m_v [N];
  int m_x [N];
  int m_y [N];
  int m_cd;
  bit m_ovr;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0;
      m_x[i] = 0;
      m_y[i] = 0;
    end
    m_cd = 0;
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_v[i];
    return c;
  endfunction

  task automatic m_move();
    if (m_cd > 0) m_cd--;
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) begin
        if (m_y[i] >= SPEED) m_y[i] -= SPEED;
        else m_v[i] = 0;
      end
    end
  endtask

  task automatic m_spawn();
    int f0 = -1;
    int f1 = -1;
    int sy;
    for (int i = 0; i < N; i++) begin
      if (!m_v[i]) begin
        if (f0 < 0) f0 = i;
        else if (f1 < 0) f1 = i;
      end
    end
    sy = (int'(player_y) >= SOFS) ? int'(player_y) - SOFS : 0;
    if (fire && m_cd == 0 && f0 >= 0) begin
`ifdef BULLET_DUAL_EN
      if (f1 >= 0) begin
        m_v[f0] = 1;
        m_x[f0] = (int'(player_x) >= DOFS) ? int'(player_x) - DOFS : 0;
        m_y[f0] = sy;
        m_v[f1] = 1;
        m_x[f1] = (int'(player_x) + DOFS > SCR_W - 1)
                ? SCR_W - 1 : int'(player_x) + DOFS;
        m_y[f1] = sy;
      end else
`endif
      begin
        m_v[f0] = 1;
        m_x[f0] = int'(player_x);
        m_y[f0] = sy;
      end
      m_cd = CD;
    end
  endtask

  function automatic bit m_hit(input int qx, input int qy);
    bit h = 0;
    for (int i = 0; i < N; i++) begin
      if (m_v[i] && qx >= m_x[i] && qx < m_x[i] + BW &&
          qy >= m_y[i] && qy < m_y[i] + BH) h = 1;
    end
    return h;
  endfunction

  task automatic compare_all(input string tag);
    logic [N-1:0] mv;
    for (int i = 0; i < N; i++) mv[i] = m_v[i];
    chk({tag, "_valid"}, bullet_valid, mv);
    chk({tag, "_count"}, active_count, m_count());
    chk({tag, "_full"}, full, (m_count() == N));
    chk({tag, "_ovr"}, overrun, m_ovr);
    for (int i = 0; i < N; i++) begin
      if (m_v[i]) begin
        chk($sformatf("%s_x%0d", tag, i), bullet_x[i*XW +: XW], m_x[i]);
        chk($sformatf("%s_y%0d", tag, i), bullet_y[i*YW +: YW], m_y[i]);
      end
    end
  endtask

  // Tick driven at negedge n0; updates done by n9; spawn visible at n10.
  task automatic do_frame(input string tag);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (8) @(negedge clk);
    m_move();
    chk({tag, "_prespawn_cnt"}, active_count, m_count());
    @(negedge clk);
    m_spawn();
    compare_all(tag);
  endtask

  task automatic do_gameover();
    gameover = 1'b1;
    @(negedge clk);
    m_clear();
    chk("go_valid", bullet_valid, 0);
    chk("go_pix", pix_hit, 0);
    gameover = 1'b0;
    @(negedge clk);
  endtask

  task automatic query(input int qx, input int qy);
    query_x = XW'(qx);
    query_y = YW'(qy);
    @(negedge clk);
    chk($sformatf("pix_%0d_%0d", qx, qy), pix_hit, m_hit(qx, qy));
  endtask

  initial begin
    m_clear();
    m_ovr = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bullet_valid, 0);
    chk("rst_count", active_count, 0);
    chk("rst_full", full, 0);
    chk("rst_pix", pix_hit, 0);
    chk("rst_ovr", overrun, 0);
    rst = 1'b1;
    @(negedge clk);

    // first spawn with exact latency
    fire = 1'b1;
    player_x = 10'd320;
    player_y = 10'd400;
    do_frame("first");
    chk("first_x0", bullet_x[XW-1:0], 320);
    chk("first_y0", bullet_y[YW-1:0], 392);

    // fire held: spawns in frames 0, 6, 12
    for (int f = 1; f <= 12; f++) do_frame("hold");
    chk("hold_count3", active_count, 3);

    // hit query on a single bullet at (320,392)
    do_gameover();
    do_frame("one");
    fire = 1'b0;
    query(322, 395);
    chk("hit_inside", pix_hit, 1);
    query(324, 392);
    chk("hit_right_edge", pix_hit, 0);
    query(319, 392);
    query(320, 399);
    query(320, 400);
    query(323, 391);
    query(322, 395);
    gameover = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    m_clear();
    chk("go_clear_valid", bullet_valid, 0);
    chk("go_clear_pix", pix_hit, 0);
    chk("go_tick_ignored", overrun, 0);
    gameover = 1'b0;
    @(negedge clk);

    // bullet reaching the top is freed and reused in the same frame
    fire = 1'b1;
    player_x = 10'd50;
    player_y = 10'd34;
    do_frame("reuse_a");
    fire = 1'b0;
    for (int f = 0; f < 6; f++) do_frame("reuse_b");
    fire = 1'b1;
    player_x = 10'd100;
    player_y = 10'd3;
    do_frame("reuse_c");
    chk("reuse_slot0_x", bullet_x[XW-1:0], 100);
    chk("reuse_slot0_y", bullet_y[YW-1:0], 0);
    chk("reuse_count", active_count, 1);

    // fill the pool, then spawn must be suppressed
    do_gameover();
    player_y = 10'd470;
    for (int f = 0; f < 43; f++) do_frame("fill");
    chk("full_flag", full, 1);
    do_frame("full_hold");
    chk("full_count", active_count, N);

    // mid-frame tick is dropped and flags overrun
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (5) @(negedge clk);
    m_move();
    @(negedge clk);
    m_spawn();
    m_ovr = 1;
    compare_all("ovr");
    @(negedge clk);
    chk("ovr_sticky", overrun, 1);

    // async reset in the middle of UPDATE with 3 live slots
    do_gameover();
    player_y = 10'd300;
    for (int f = 0; f < 13; f++) do_frame("pre_rst");
    chk("pre_rst_count", active_count, 3);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    m_clear();
    m_ovr = 0;
    chk("arst_valid", bullet_valid, 0);
    chk("arst_count", active_count, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_pix", pix_hit, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fire = 1'b0;
    do_frame("post_rst");

    // randomised frames
    for (int k = 0; k < 80; k++) begin
      int s;
      fire = ($urandom_range(0, 3) != 0);
      player_x = XW'($urandom_range(0, SCR_W - 1));
      player_y = YW'($urandom_range(0, 479));
      if ($urandom_range(0, 24) == 0) do_gameover();
      else do_frame("rnd");
      s = $urandom_range(0, N - 1);
      query(m_x[s] + $urandom_range(0, BW + 1) - 1,
            m_y[s] + $urandom_range(0, BH + 1) - 1);
      query($urandom_range(0, SCR_W - 1), $urandom_range(0, 479));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
